// File: rtl/flag_branch_pkg.sv
// rtl/flag_branch_pkg.sv - shared types and the default branch target table for flag_branch_unit
package flag_branch_pkg;

    typedef enum logic [1:0] {
        FETCH   = 2'b00,
        EXEC    = 2'b01,
        RESOLVE = 2'b10,
        COMMIT  = 2'b11
    } stage_t;

    typedef enum logic [2:0] {
        COND_ALWAYS = 3'b000,
        COND_EQ     = 3'b001,
        COND_NE     = 3'b010,
        COND_GT     = 3'b011,
        COND_LT     = 3'b100,
        COND_GE     = 3'b101,
        COND_CS     = 3'b110,
        COND_CC     = 3'b111
    } br_cond_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } state_t;

    localparam int LUT_DEPTH = 16;

    // Absolute branch targets; entries wider than the pc are truncated at the use site.
    localparam logic [15:0] TARGET_LUT [LUT_DEPTH] = '{
        16'd0,   16'd17,  16'd40,  16'd100,
        16'd128, 16'd200, 16'd256, 16'd300,
        16'd384, 16'd450, 16'd512, 16'd600,
        16'd700, 16'd800, 16'd900, 16'd1023
    };

endpackage

// File: rtl/branch_cond_eval.sv
// rtl/branch_cond_eval.sv - combinational branch condition check against stored flags and carry
module branch_cond_eval
    import flag_branch_pkg::*;
(
    input  logic [2:0] br_cond,
    input  logic [3:0] flags,
    input  logic       c_i,
    output logic       cond_true
);

    // flags is packed {gt, lt, equal, zero}
    logic w_gt;
    logic w_lt;
    logic w_eq;

    assign w_gt = flags[3];
    assign w_lt = flags[2];
    assign w_eq = flags[1];

    always_comb begin
        cond_true = 1'b0;
        case (br_cond_t'(br_cond))
            COND_ALWAYS: cond_true = 1'b1;
            COND_EQ:     cond_true = w_eq;
            COND_NE:     cond_true = !w_eq;
            COND_GT:     cond_true = w_gt;
            COND_LT:     cond_true = w_lt;
            COND_GE:     cond_true = w_gt | w_eq;
            COND_CS:     cond_true = c_i;
            COND_CC:     cond_true = !c_i;
            default:     cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_branch_unit.sv
// rtl/flag_branch_unit.sv - flag/carry capture, branch resolve, pc and run/halt FSM; FLAG_BRANCH_LUT_EN selects absolute LUT targets
module flag_branch_unit
    import flag_branch_pkg::*;
#(
    parameter int PC_W  = 10,
    parameter int OFF_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       stage,
    input  logic             start,
    input  logic             flag_we,
    input  logic             carry_we,
    input  logic             alu_c_o,
    input  logic             alu_equal,
    input  logic             alu_gt,
    input  logic             alu_lt,
    input  logic             alu_zero,
    input  logic             br_en,
    input  logic [2:0]       br_cond,
    input  logic [OFF_W-1:0] br_offset,
    input  logic             halt_req,
    output logic             c_i,
    output logic [3:0]       flags,
    output logic [PC_W-1:0]  pc,
    output logic             taken,
    output logic             running,
    output logic             halted
);

    state_t          r_state;
    logic [3:0]      r_flags;
    logic            r_c;
    logic            r_taken;
    logic [PC_W-1:0] r_pc;

    stage_t          w_stage;
    logic            w_cond_true;
    logic [PC_W-1:0] w_br_target;
    logic [PC_W-1:0] w_pc_next;

    assign w_stage = stage_t'(stage);

    branch_cond_eval u_cond_eval (
        .br_cond   (br_cond),
        .flags     (r_flags),
        .c_i       (r_c),
        .cond_true (w_cond_true)
    );

`ifdef FLAG_BRANCH_LUT_EN
    assign w_br_target = PC_W'(TARGET_LUT[br_offset[3:0]]);
`else
    // Sign-extend the offset to pc width; the add wraps naturally.
    assign w_br_target = r_pc + PC_W'($signed(br_offset));
`endif

    assign w_pc_next = r_taken ? w_br_target : r_pc + PC_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_flags <= 4'b0000;
            r_c     <= 1'b0;
            r_taken <= 1'b0;
            r_pc    <= '0;
        end else begin
            case (r_state)
                IDLE, HALT: begin
                    if (start) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    case (w_stage)
                        EXEC: begin
                            if (flag_we) begin
                                r_flags <= {alu_gt, alu_lt, alu_equal, alu_zero};
                            end
                            if (carry_we) begin
                                r_c <= alu_c_o;
                            end
                        end
                        RESOLVE: begin
                            r_taken <= br_en & w_cond_true;
                        end
                        COMMIT: begin
                            r_pc    <= w_pc_next;
                            r_taken <= 1'b0;
                            if (halt_req) begin
                                r_state <= HALT;
                            end
                        end
                        default: ;
                    endcase
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign c_i     = r_c;
    assign flags   = r_flags;
    assign pc      = r_pc;
    assign taken   = r_taken;
    assign running = (r_state == RUN);
    assign halted  = (r_state == HALT);

endmodule

// File: tb/tb_flag_branch_unit.sv
// tb/tb_flag_branch_unit.sv - directed and randomized self-checking bench for flag_branch_unit
module tb_flag_branch_unit;
    import flag_branch_pkg::*;

    localparam int PC_W  = 10;
    localparam int OFF_W = 8;
    localparam int PC_MOD = 1 << PC_W;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [1:0]       stage = 2'b00;
    logic             start = 1'b0;
    logic             flag_we = 1'b0;
    logic             carry_we = 1'b0;
    logic             alu_c_o = 1'b0;
    logic             alu_equal = 1'b0;
    logic             alu_gt = 1'b0;
    logic             alu_lt = 1'b0;
    logic             alu_zero = 1'b0;
    logic             br_en = 1'b0;
    logic [2:0]       br_cond = 3'b000;
    logic [OFF_W-1:0] br_offset = '0;
    logic             halt_req = 1'b0;
    logic             c_i;
    logic [3:0]       flags;
    logic [PC_W-1:0]  pc;
    logic             taken;
    logic             running;
    logic             halted;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: plain variables, 0 = idle, 1 = run, 2 = halt
    int m_pc;
    bit m_gt, m_lt, m_eq, m_z, m_c, m_taken;
    int m_st;
    bit tk_at_resolve;

    flag_branch_unit #(.PC_W(PC_W), .OFF_W(OFF_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .stage     (stage),
        .start     (start),
        .flag_we   (flag_we),
        .carry_we  (carry_we),
        .alu_c_o   (alu_c_o),
        .alu_equal (alu_equal),
        .alu_gt    (alu_gt),
        .alu_lt    (alu_lt),
        .alu_zero  (alu_zero),
        .br_en     (br_en),
        .br_cond   (br_cond),
        .br_offset (br_offset),
        .halt_req  (halt_req),
        .c_i       (c_i),
        .flags     (flags),
        .pc        (pc),
        .taken     (taken),
        .running   (running),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit cond_ok(input int code);
        case (code)
            0: return 1'b1;
            1: return m_eq;
            2: return !m_eq;
            3: return m_gt;
            4: return m_lt;
            5: return m_gt || m_eq;
            6: return m_c;
            default: return !m_c;
        endcase
    endfunction

    task automatic model_edge();
        int off;
        off = int'($signed(br_offset));
        if (reset) begin
            m_pc = 0; m_gt = 0; m_lt = 0; m_eq = 0; m_z = 0; m_c = 0; m_taken = 0; m_st = 0;
        end else if (m_st != 1) begin
            if (start) m_st = 1;
        end else begin
            case (int'(stage))
                1: begin
                    if (flag_we) begin
                        m_gt = alu_gt; m_lt = alu_lt; m_eq = alu_equal; m_z = alu_zero;
                    end
                    if (carry_we) m_c = alu_c_o;
                end
                2: m_taken = br_en && cond_ok(int'(br_cond));
                3: begin
`ifdef FLAG_BRANCH_LUT_EN
                    if (m_taken) m_pc = int'(TARGET_LUT[int'(br_offset[3:0])]) % PC_MOD;
`else
                    if (m_taken) m_pc = ((m_pc + off) % PC_MOD + PC_MOD) % PC_MOD;
`endif
                    else m_pc = (m_pc + 1) % PC_MOD;
                    m_taken = 0;
                    if (halt_req) m_st = 2;
                end
                default: ;
            endcase
        end
    endtask

    task automatic step(input int st, input bit rst_v, input bit start_v);
        stage = 2'(st);
        reset = rst_v;
        start = start_v;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("pc", 32'(pc), 32'(m_pc));
        check("flags", 32'(flags), 32'({m_gt, m_lt, m_eq, m_z}));
        check("c_i", 32'(c_i), 32'(m_c));
        check("taken", 32'(taken), 32'(m_taken));
        check("running", 32'(running), 32'(m_st == 1));
        check("halted", 32'(halted), 32'(m_st == 2));
    endtask

    // One instruction over four stages; ALU inputs and enables are random outside EXEC.
    task automatic instr(input bit fwe, input bit cwe, input bit co, input logic [3:0] f,
                         input bit ben, input int cond, input int off, input bit hlt);
        br_en = ben;
        br_cond = 3'(cond);
        br_offset = OFF_W'(off);
        halt_req = hlt;
        for (int s = 0; s < 4; s++) begin
            if (s == 1) begin
                flag_we = fwe; carry_we = cwe; alu_c_o = co;
                {alu_gt, alu_lt, alu_equal, alu_zero} = f;
            end else begin
                flag_we = 1'($urandom); carry_we = 1'($urandom); alu_c_o = 1'($urandom);
                {alu_gt, alu_lt, alu_equal, alu_zero} = 4'($urandom);
            end
            step(s, 1'b0, 1'b0);
            if (s == 2) tk_at_resolve = taken;
        end
        halt_req = 1'b0;
    endtask

    initial begin
        // Reset and start
        step(0, 1'b1, 1'b0);
        check("rst_pc", 32'(pc), 0);
        check("rst_flags", 32'(flags), 0);
        check("rst_c", 32'(c_i), 0);
        check("rst_running", 32'(running), 0);
        check("rst_halted", 32'(halted), 0);
        step(0, 1'b0, 1'b1);
        check("start_running", 32'(running), 1);

        for (int i = 0; i < 3; i++) begin
            instr(0, 0, 0, 4'b0000, 0, 0, 0, 0);
            check("seq_pc", 32'(pc), 32'(i + 1));
        end
        instr(1, 0, 0, 4'b0010, 0, 0, 0, 0);
        check("cmp_pc", 32'(pc), 4);
        instr(0, 0, 0, 4'b0000, 1, 1, 5, 0);
`ifndef FLAG_BRANCH_LUT_EN
        check("beq_taken", 32'(tk_at_resolve), 1);
        check("beq_pc", 32'(pc), 9);
        instr(1, 0, 0, 4'b0010, 0, 0, 0, 0);
        instr(0, 0, 0, 4'b0000, 1, 2, 5, 0);
        check("bne_taken", 32'(tk_at_resolve), 0);
        check("bne_pc", 32'(pc), 11);
        instr(0, 1, 1, 4'b1101, 0, 0, 0, 0);
        check("add_c", 32'(c_i), 1);
        check("flags_hold", 32'(flags), 32'(4'b0010));
        instr(0, 0, 0, 4'b0000, 1, 6, -3, 0);
        check("bcs_pc", 32'(pc), 9);
        instr(0, 0, 0, 4'b0000, 1, 0, -9, 0);
        instr(0, 0, 0, 4'b0000, 1, 0, -1, 0);
        check("wrap_neg", 32'(pc), 1023);
        instr(0, 0, 0, 4'b0000, 0, 0, 0, 0);
        check("wrap_pos", 32'(pc), 0);
        instr(0, 0, 0, 4'b0000, 1, 0, 20, 0);
        instr(0, 0, 0, 4'b0000, 1, 0, 2, 1);
        check("halt_pc", 32'(pc), 22);
        check("halt_flag", 32'(halted), 1);
        for (int i = 0; i < 10; i++) begin
            flag_we = 1'b1; carry_we = 1'b1; br_en = 1'b1;
            {alu_gt, alu_lt, alu_equal, alu_zero, alu_c_o} = 5'($urandom);
            step(int'($urandom_range(3)), 1'b0, 1'b0);
        end
        check("halt_hold_pc", 32'(pc), 22);
        step(0, 1'b0, 1'b1);
        check("resume_running", 32'(running), 1);
        instr(0, 0, 0, 4'b0000, 0, 0, 0, 0);
        check("resume_pc", 32'(pc), 23);
`else
        step(0, 1'b0, 1'b0);
        instr(0, 0, 0, 4'b0000, 1, 0, 3, 0);
        check("lut_pc", 32'(pc), 32'(int'(TARGET_LUT[3]) % PC_MOD));
`endif

        // Reset on the resolve edge of a taken branch
        br_en = 1'b1; br_cond = 3'b000; br_offset = OFF_W'(5); halt_req = 1'b0;
        flag_we = 1'b0; carry_we = 1'b0;
        step(0, 1'b0, 1'b0);
        flag_we = 1'b1; carry_we = 1'b1; alu_c_o = 1'b1;
        {alu_gt, alu_lt, alu_equal, alu_zero} = 4'b1000;
        step(1, 1'b0, 1'b0);
        step(2, 1'b1, 1'b0);
        check("mrst_pc", 32'(pc), 0);
        check("mrst_flags", 32'(flags), 0);
        check("mrst_c", 32'(c_i), 0);
        check("mrst_taken", 32'(taken), 0);
        check("mrst_idle", 32'(running | halted), 0);

        // Randomized instruction stream against the model
        for (int i = 0; i < 250; i++) begin
            if (m_st != 1) step(int'($urandom_range(3)), 1'b0, 1'b1);
            instr(1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom),
                  1'($urandom), int'($urandom_range(7)), int'($urandom_range(255)) - 128,
                  ($urandom_range(15) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/flag_branch_unit.md
Name: flag_branch_unit

Overview:
- Consumer end of the ALU flag/carry interface.
- Registers the ALU's compare and carry outputs during the execute stage, and feeds the stored carry back to the ALU carry-in.
- Resolves conditional branches from the stored flags and owns the program counter plus the run/halt state of the core.
- Sits between the stage sequencer, the ALU and instruction fetch.

Parameters:
- PC_W, 10, program counter width in bits; all PC arithmetic wraps modulo 2^PC_W.
- OFF_W, 8, branch offset width in bits; the offset is signed two's complement.

Ports:
- clk  in  1  core clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; sampled on posedge clk.
- stage  in  2  pipeline stage from the sequencer: 00 fetch, 01 execute, 10 resolve, 11 commit.
- start  in  1  leave IDLE/HALT and begin execution at the current pc.
- flag_we  in  1  current instruction updates the flags (compare, arithmetic, shift).
- carry_we  in  1  current instruction updates the stored carry.
- alu_c_o  in  1  ALU carry out.
- alu_equal  in  1  ALU equal flag.
- alu_gt  in  1  ALU signed greater-than flag.
- alu_lt  in  1  ALU signed less-than flag.
- alu_zero  in  1  ALU zero flag.
- br_en  in  1  current instruction is a branch.
- br_cond  in  3  branch condition code.
- br_offset  in  OFF_W  signed branch offset, or LUT index when the optional feature is on.
- halt_req  in  1  current instruction is a halt.
- c_i  out  1  stored carry, driven to the ALU carry-in.
- flags  out  4  registered {gt, lt, equal, zero}.
- pc  out  PC_W  program counter.
- taken  out  1  branch decision for the current instruction.
- running  out  1  high in RUN.
- halted  out  1  high in HALT.

Behaviour:
- Reset: pc=0, flags=0, c_i=0, taken=0, state=IDLE, running=0, halted=0. Reset overrides every other input on the same edge, mid-instruction included; there is no partial commit.
- FSM states: IDLE, RUN, HALT.
  - IDLE -> RUN on start.
  - RUN -> HALT at a commit edge (stage==11) with halt_req=1.
  - HALT -> RUN on start; pc is unchanged.
  - start while in RUN is ignored.
- Flag capture: only in RUN, only on the posedge where stage==01.
  - flag_we=1: flags <= {alu_gt, alu_lt, alu_equal, alu_zero}.
  - carry_we=1: c_i <= alu_c_o.
  - Both enables are independent; when low, the register holds.
  - Enables asserted in any other stage are ignored.
- Resolve: on the posedge where stage==10 in RUN, taken <= br_en & cond(br_cond, flags, c_i). Flags written by an instruction are visible to a branch in the next instruction, not the same one.
- Condition codes (br_cond):
  - 000 ALWAYS
  - 001 EQ (equal)
  - 010 NE (!equal)
  - 011 GT (gt)
  - 100 LT (lt)
  - 101 GE (gt|equal)
  - 110 CS (c_i)
  - 111 CC (!c_i)
- Commit: on the posedge where stage==11 in RUN:
  - pc <= taken ? pc + sext(br_offset) : pc + 1, truncated to PC_W bits. Wrap-around is legal: pc=max with +1 gives 0; pc=0 with offset -1 gives max.
  - taken clears to 0 after commit.
- halt_req together with a taken branch at commit: the branch pc update applies, then the FSM enters HALT.
- In IDLE/HALT: pc, flags, c_i and taken all hold; stage activity is ignored.
- Latency: flags to branch decision is one instruction; decision to pc update is one stage.

Optional Feature:
- Macro: FLAG_BRANCH_LUT_EN.
- Defined: a taken branch loads pc <= target_lut[br_offset[3:0]]. target_lut is a 16 x PC_W table of absolute targets, loaded from the package constant; br_offset[OFF_W-1:4] is ignored.
- Undefined: relative branching as above; no LUT is instantiated.

Decomposition:
- Package flag_branch_pkg:
  - stage_t enum (FETCH, EXEC, RESOLVE, COMMIT)
  - br_cond_t enum (the 8 codes above)
  - fsm state_t enum (IDLE, RUN, HALT)
  - the default 16-entry target LUT constant
- Sub-module branch_cond_eval: purely combinational; inputs br_cond, flags, c_i; output cond_true. Top-level keeps all registers and the FSM.

Test Plan:
- Reset then start; 3 instructions with no branch -> pc steps 0, 1, 2, 3 at each commit; taken stays 0.
- Compare with alu_equal=1 and flag_we=1, next instruction BEQ offset=+5 at pc=4 -> taken=1 at resolve; pc=9 after commit. Same sequence with BNE -> pc=5.
- ADD with alu_c_o=1 and carry_we=1 -> c_i=1. Next BCS offset=-3 at pc=10 -> pc=7. flag_we asserted at stage 10 with different ALU flags -> flags unchanged.
- pc=1023 (PC_W=10) with no branch -> pc=0. pc=0 with ALWAYS offset=-1 -> pc=1023.
- halt_req together with ALWAYS offset=+2 at pc=20 -> pc=22, halted=1, pc holds for 10 cycles; start -> running=1 and the next commit gives pc=23.
- Reset asserted at stage 10 of a taken branch -> next cycle pc=0, flags=0, c_i=0, taken=0, state IDLE. With FLAG_BRANCH_LUT_EN defined: ALWAYS br_offset=3 -> pc=target_lut[3].
